// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: divisor load channel for clk_div_prog.
//   div_in    - requested divisor (output period in clk cycles)
//   div_valid - div_in is offered by the master
//   div_ready - the divider's pending slot is empty and can take an offer
// modport master: drives div_in/div_valid, observes div_ready.
// modport slave : the divider side.
interface clk_div_prog_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;

    modport master (output div_in, output div_valid, input div_ready);
    modport slave  (input div_in, input div_valid, output div_ready);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with a runtime-loadable divisor.
// A new divisor is accepted into a one-entry pending slot and applied only
// at a period boundary (or while stopped), so div_clk never shows a runt.
//
// Ports:
//   clk     - system clock, rising edge
//   resetn  - synchronous active-low reset
//   en      - run enable; when low the divider is held at phase 0
//   div_if  - divisor load channel (slave modport of clk_div_prog_if)
//   div_clk - registered divided clock level (low floor(D/2), high ceil(D/2))
//   tick    - one-cycle pulse at each period start
//   count   - current phase counter (debug)
//
// Build option: define CLKDIV_PROG_TICK_EN to build the tick register;
// otherwise tick is tied low.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    clk_div_prog_if.slave    div_if,
    output logic             div_clk,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    typedef enum logic {
        ST_STOP,
        ST_RUN
    } run_state_t;

    run_state_t       r_state;
    run_state_t       w_state_n;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] w_div_q_n;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_pend_n;
    logic             r_pend_v;
    logic             w_pend_v_n;
    logic             r_div_clk;
    logic             w_div_clk_n;
    logic             w_accept;
    logic             w_boundary;

    // A period starts on a wrap, and also on the first enabled edge after a
    // stop so that re-enabling always begins cleanly at phase 0.
    assign w_boundary = en && ((r_state == ST_STOP) ||
                               (r_cnt == r_div_q - WIDTH'(1)));
    assign w_accept   = div_if.div_valid && !r_pend_v;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_div_q_n  = r_div_q;
        w_pend_n   = r_pend;
        w_pend_v_n = r_pend_v;

        if (!en || w_boundary) begin
            w_state_n = en ? ST_RUN : ST_STOP;
            w_cnt_n   = '0;
            if (r_pend_v) begin
                w_div_q_n  = r_pend;
                w_pend_v_n = 1'b0;
            end
        end else begin
            w_cnt_n = r_cnt + WIDTH'(1);
        end

        // Acceptance needs an empty slot, so it never collides with an apply.
        if (w_accept) begin
            w_pend_n   = (div_if.div_in < WIDTH'(2)) ? WIDTH'(2) : div_if.div_in;
            w_pend_v_n = 1'b1;
        end

        // Decoded from next-state values so the register matches cnt/div_q.
        w_div_clk_n = (w_cnt_n >= (w_div_q_n >> 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_div_q   <= WIDTH'(DEFAULT_DIV);
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_div_clk <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_div_q   <= w_div_q_n;
            r_pend    <= w_pend_n;
            r_pend_v  <= w_pend_v_n;
            r_div_clk <= w_div_clk_n;
        end
    end

`ifdef CLKDIV_PROG_TICK_EN
    logic r_tick;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_boundary;
        end
    end

    assign tick = r_tick;
`else
    assign tick = 1'b0;
`endif

    assign div_if.div_ready = !r_pend_v;
    assign div_clk          = r_div_clk;
    assign count            = r_cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random
// stimulus, compared every cycle against a period-level reference model.
module tb_clk_div_prog;

    localparam int unsigned W   = 16;
    localparam int unsigned DEF = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         en;
    logic         div_clk;
    logic         tick;
    logic [W-1:0] count;

    clk_div_prog_if #(.WIDTH(W)) u_if ();

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .div_if (u_if.slave),
        .div_clk(div_clk),
        .tick   (tick),
        .count  (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles elapsed in the current period, active period
    // length, and a queue of accepted-but-not-yet-applied divisors.
    int unsigned m_phase   = 0;
    int unsigned m_D       = DEF;
    bit          m_running = 1'b0;
    bit          m_tick    = 1'b0;
    bit          m_acc     = 1'b0;
    int unsigned m_pend[$];
    int unsigned m_applied[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned clampd(input int unsigned v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_edge();
        bit boundary;
        m_acc = 1'b0;
        if (!resetn) begin
            m_phase   = 0;
            m_D       = DEF;
            m_running = 1'b0;
            m_tick    = 1'b0;
            m_pend.delete();
        end else begin
            m_acc    = u_if.div_valid && (m_pend.size() == 0);
            boundary = en && (!m_running || (m_phase + 1 == m_D));
            if (!en || boundary) begin
                if (m_pend.size() != 0) begin
                    m_D = m_pend.pop_front();
                    m_applied.push_back(m_D);
                end
                m_phase = 0;
            end else begin
                m_phase++;
            end
            m_tick    = boundary;
            m_running = en;
            if (m_acc) m_pend.push_back(clampd(int'(u_if.div_in)));
        end
    endtask

    task automatic compare();
        chk("count", count, m_phase);
        chk("div_clk", div_clk, (m_phase >= m_D / 2));
        chk("div_ready", u_if.div_ready, (m_pend.size() == 0));
`ifdef CLKDIV_PROG_TICK_EN
        chk("tick", tick, m_tick);
`else
        chk("tick", tick, 0);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic offer(input int unsigned v);
        u_if.div_valid = 1'b1;
        u_if.div_in    = W'(v);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (m_acc) break;
        end
        chk("offer_accepted", m_acc, 1);
        u_if.div_valid = 1'b0;
    endtask

    task automatic wait_period(input int unsigned d);
        for (int i = 0; i < 200; i++) begin
            if (m_D == d && m_phase == 0) break;
            cyc();
        end
        chk("period_start_seen", (m_D == d && m_phase == 0), 1);
    endtask

    initial begin
        logic [7:0] pat8;
        logic [7:0] tk8;
        logic [4:0] pat5;
        logic [1:0] pat2;

        resetn         = 1'b0;
        en             = 1'b0;
        u_if.div_valid = 1'b0;
        u_if.div_in    = '0;
        run(2);
        chk("rst_count", count, 0);
        chk("rst_div_clk", div_clk, 0);
        chk("rst_ready", u_if.div_ready, 1);
        chk("rst_tick", tick, 0);

        // Default D=4: div_clk 0,0,1,1 repeating, tick at count 0.
        resetn = 1'b1;
        en     = 1'b1;
        pat8   = '0;
        tk8    = '0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            pat8 = {pat8[6:0], div_clk};
            tk8  = {tk8[6:0], tick};
        end
        chk("d4_pattern", pat8, 8'b0011_0011);
`ifdef CLKDIV_PROG_TICK_EN
        chk("d4_tick_pattern", tk8, 8'b1000_1000);
`else
        chk("d4_tick_pattern", tk8, 8'b0000_0000);
`endif

        // Mid-period load of 5.
        run(2);
        offer(5);
        chk("ready_low_after_accept", u_if.div_ready, 0);
        wait_period(5);
        pat5 = {4'b0, div_clk};
        for (int i = 0; i < 4; i++) begin
            cyc();
            pat5 = {pat5[3:0], div_clk};
        end
        chk("d5_pattern", pat5, 5'b00111);

        // Clamp of 0 and 1 to period 2.
        offer(0);
        wait_period(2);
        cyc();
        pat2 = {div_clk, 1'b0};
        cyc();
        pat2[0] = div_clk;
        chk("d2_pattern", pat2, 2'b10);
        offer(1);
        run(6);
        chk("clamp1_period", m_D, 2);

        // Back-to-back offers 7 then 9.
        offer(7);
        offer(9);
        run(30);
        chk("applied_7", m_applied[m_applied.size() - 2], 7);
        chk("applied_9", m_applied[m_applied.size() - 1], 9);

        // Stop mid-period with 6 pending.
        run(3);
        u_if.div_valid = 1'b1;
        u_if.div_in    = W'(6);
        cyc();
        u_if.div_valid = 1'b0;
        en             = 1'b0;
        cyc();
        chk("stop_count", count, 0);
        chk("stop_div_clk", div_clk, 0);
        chk("stop_tick", tick, 0);
        chk("stop_applied_6", m_D, 6);
        en = 1'b1;
        cyc();
`ifdef CLKDIV_PROG_TICK_EN
        chk("restart_tick", tick, 1);
`else
        chk("restart_tick", tick, 0);
`endif
        run(12);

        // Reset while running D=9 with a pending load.
        offer(9);
        wait_period(9);
        run(3);
        offer(5);
        resetn = 1'b0;
        cyc();
        chk("midrst_count", count, 0);
        chk("midrst_ready", u_if.div_ready, 1);
        chk("midrst_div_clk", div_clk, 0);
        resetn = 1'b1;
        pat8   = '0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            pat8 = {pat8[6:0], div_clk};
        end
        chk("post_rst_d4_pattern", pat8, 8'b0011_0011);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            en     = ($urandom_range(0, 15) != 0);
            if (u_if.div_valid && m_acc) u_if.div_valid = 1'b0;
            if (!u_if.div_valid && $urandom_range(0, 7) == 0) begin
                u_if.div_valid = 1'b1;
                u_if.div_in    = W'($urandom_range(0, 12));
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock divider: replaces fixed-ratio dividers with a runtime-loadable, parameter-width divisor. Produces a divided clock-level output and an optional single-cycle period tick from one system clock. The divisor is loaded through a valid/ready handshake and takes effect only at a period boundary, so the output has no runt phase. It sits beside the VGA and peripheral timing logic, fed directly from the board clock.

## Interface
- `WIDTH`, default 16: divisor and counter width in bits.
- `DEFAULT_DIV`, default 4: divisor after reset. Must be ≥2 and < 2^WIDTH.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `en`  in  1  run enable. When 0, the divider is stopped and clean.
- `div_in`  in  WIDTH  requested divisor: output period in `clk` cycles.
- `div_valid`  in  1  `div_in` is offered.
- `div_ready`  out  1  pending slot is empty, so an offer can be accepted.
- `div_clk`  out  1  divided clock-level output, registered.
- `tick`  out  1  one-cycle pulse at each period start. Present under `CLKDIV_PROG_TICK_EN`.
- `count`  out  WIDTH  current phase counter, for debug and verification.

## Operation
- Registers:
  - `cnt` (WIDTH bits): phase counter.
  - `div_q` (WIDTH bits): active divisor.
  - `pend` / `pend_v`: one-entry pending divisor and its valid flag.
  - `div_clk` and `tick`.
- Invariant, every cycle: `div_clk == (cnt >= (div_q >> 1))`. `div_clk` is computed from next-state values, not decoded after the register.
- Duty cycle:
  - Even D: low for D/2 cycles, then high for D/2.
  - Odd D: low for floor(D/2) cycles, then high for ceil(D/2).
- Load handshake:
  - An offer is accepted when `div_valid && div_ready`. The value goes into `pend` and `pend_v` is set.
  - `div_ready = !pend_v`.
  - On acceptance, `div_in < 2` is clamped to 2.
- Running (`en`=1):
  - Wrap: when `cnt == div_q-1`, `cnt` goes to 0.
  - At a wrap with `pend_v`=1: `div_q <= pend` and `pend_v` clears.
  - All other cycles: `cnt <= cnt+1`.
- Stopped (`en`=0):
  - `cnt` is held at 0, so `div_clk`=0 and `tick`=0.
  - If `pend_v`=1, `pend` is applied on the next edge and `pend_v` clears.
- `tick`=1 in exactly the cycles where `cnt==0` following a wrap, or following the first enabled cycle after a stop. It is never asserted while `en`=0.
- Simultaneous events:
  - Acceptance in a wrap cycle while `pend_v`=0: the value is stored and applied at the next wrap. There is no same-cycle bypass.
  - Apply and a new offer in the same cycle cannot happen, because `div_ready`=0 whenever `pend_v`=1. `div_ready` rises on the cycle after the apply.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending divisor is discarded.

## Timing
- Reset values:
  - `cnt`=0, `div_q`=`DEFAULT_DIV`
  - `pend_v`=0, so `div_ready`=1
  - `div_clk`=0, `tick`=0, `count`=0
- `en` rising at edge k: `cnt`=0 during cycle k+1 with `tick`=1. `div_clk` rises `div_q>>1` cycles later.
- `en` falling: `cnt` and `div_clk` are 0 from the next edge. Re-enabling always starts from phase 0.
- Output period = D `clk` cycles. This holds for any D in [2, 2^WIDTH-1].
- New divisor latency: it takes effect in the first cycle with `cnt`=0 after the current period completes. Worst case is D_old cycles after acceptance.
- Wrap-around: `cnt` never exceeds `div_q-1`, so it never overflows WIDTH.

## Configuration
- `CLKDIV_PROG_TICK_EN` defined:
  - The `tick` register and logic are built.
  - `tick` behaves as described under Operation.
- `CLKDIV_PROG_TICK_EN` undefined:
  - The `tick` logic is omitted and the port is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, `en`=1, no load (D=4): `div_clk` repeats 0,0,1,1 and `count` repeats 0,1,2,3. `tick` is high only when `count`=0 (macro defined).
- Load `div_in`=5 in the middle of a period: `div_ready` drops on the next cycle. The old period completes, then `div_clk` runs 0,0,1,1,1 repeating. `div_ready` returns to 1 one cycle after the apply.
- Load `div_in`=0, then `div_in`=1: each clamps to 2, and `div_clk` toggles every cycle (period 2).
- Two back-to-back offers (7, then 9) while the first is pending: the second waits with `div_ready`=0. The period becomes 7, then 9 from the next boundary. No value is lost or duplicated.
- `en`=0 mid-period with `div_in`=6 pending: `count`, `div_clk` and `tick` are 0 on the next edge and the pending value is applied. After `en`=1 the period is 6, starting with `tick`.
- `resetn`=0 for one cycle while running D=9 with a pending load: all outputs return to reset values, the pending load is dropped, and operation resumes with D=4.
